// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the rr_select_mux block.
package rr_mux_pkg;

    typedef enum logic {MODE_EXPLICIT = 1'b0, MODE_RR = 1'b1} mux_mode_e;

    // Index following idx, wrapping at n; n need not be a power of 2.
    function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned n);
        return (idx >= n - 32'd1) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Rotating priority picker: first set request at or after ptr, wrapping modulo N.
module rr_prio_pick #(
    parameter  int unsigned N    = 8,
    localparam int unsigned SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_valid,
    output logic [SELW-1:0] gnt_idx
);

    int unsigned idx;

    // Explicit subtract instead of a power-of-2 mask so any N wraps correctly.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = 32'(ptr) + off;
            if (idx >= N) idx = idx - N;
            if (!gnt_valid && req[SELW'(idx)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SELW'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_select_mux.sv
// Registered N-way selector with valid/ready on every side: explicit select or round-robin.
// Optional RR grant locking (in_lock port and lock state) is built when RR_MUX_LOCK_EN is defined.
module rr_select_mux
    import rr_mux_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned N     = 8,
    localparam int unsigned SELW  = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic [SELW-1:0]  sel,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic [WIDTH-1:0] in_data [N],
`ifdef RR_MUX_LOCK_EN
    input  logic [N-1:0]     in_lock,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SELW-1:0]  out_src
);

    logic             rr_c, load_c, fire_c, sel_hit_c;
    logic             gnt_valid_c, rr_valid_c;
    logic [SELW-1:0]  gnt_idx_c, rr_idx_c, ptr;
    logic [N-1:0]     rr_req_c;
    logic [WIDTH-1:0] gnt_data_c;

    assign rr_c   = (mux_mode_e'(mode) == MODE_RR);
    assign load_c = !out_valid || out_ready;

`ifdef RR_MUX_LOCK_EN
    logic            lock_q;
    logic [SELW-1:0] lock_ch;

    // While locked only the holder is eligible; explicit mode drops the lock.
    assign rr_req_c = lock_q ? (in_valid & (N'(1) << lock_ch)) : in_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q  <= 1'b0;
            lock_ch <= '0;
        end else if (!rr_c) begin
            lock_q  <= 1'b0;
        end else if (fire_c) begin
            lock_q  <= in_lock[gnt_idx_c];
            lock_ch <= gnt_idx_c;
        end
    end
`else
    assign rr_req_c = in_valid;
`endif

    rr_prio_pick #(.N(N)) u_pick (
        .req       (rr_req_c),
        .ptr       (ptr),
        .gnt_valid (rr_valid_c),
        .gnt_idx   (rr_idx_c)
    );

    // Loop compares keep sel values >= N from ever addressing a channel.
    always_comb begin
        sel_hit_c  = 1'b0;
        gnt_data_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (32'(sel) == i) sel_hit_c = in_valid[i];
        end
        gnt_valid_c = rr_c ? rr_valid_c : sel_hit_c;
        gnt_idx_c   = rr_c ? rr_idx_c : sel;
        for (int unsigned i = 0; i < N; i++) begin
            if (32'(gnt_idx_c) == i) gnt_data_c = in_data[i];
        end
    end

    assign fire_c   = gnt_valid_c && load_c && !reset;
    assign in_ready = fire_c ? (N'(1) << gnt_idx_c) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else if (load_c) begin
            out_valid <= fire_c;
            if (fire_c) begin
                out_data <= gnt_data_c;
                out_src  <= gnt_idx_c;
                if (rr_c) ptr <= SELW'(next_ptr(32'(gnt_idx_c), N));
            end
        end
    end

endmodule

// File: tb/tb_rr_select_mux.sv
// Bench for rr_select_mux: N=8 against a cycle model plus directed N=5 and N=3 instances.
module tb_rr_select_mux;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    logic        mode8 = 1'b0, ov8, or8 = 1'b1;
    logic [2:0]  sel8 = '0, os8;
    logic [7:0]  valid8 = '0, ready8, lock8 = '0;
    logic [31:0] data8 [8];
    logic [31:0] od8;

    logic        mode5 = 1'b1, ov5, or5 = 1'b1;
    logic [2:0]  sel5 = '0, os5;
    logic [4:0]  valid5 = '0, ready5, lock5 = '0;
    logic [31:0] data5 [5];
    logic [31:0] od5;

    logic        mode3 = 1'b0, ov3, or3 = 1'b1;
    logic [1:0]  sel3 = '0, os3;
    logic [2:0]  valid3 = '0, ready3, lock3 = '0;
    logic [31:0] data3 [3];
    logic [31:0] od3;

    rr_select_mux #(.WIDTH(32), .N(8)) dut8 (
        .clk(clk), .reset(reset), .mode(mode8), .sel(sel8),
        .in_valid(valid8), .in_ready(ready8), .in_data(data8),
`ifdef RR_MUX_LOCK_EN
        .in_lock(lock8),
`endif
        .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_src(os8));

    rr_select_mux #(.WIDTH(32), .N(5)) dut5 (
        .clk(clk), .reset(reset), .mode(mode5), .sel(sel5),
        .in_valid(valid5), .in_ready(ready5), .in_data(data5),
`ifdef RR_MUX_LOCK_EN
        .in_lock(lock5),
`endif
        .out_valid(ov5), .out_ready(or5), .out_data(od5), .out_src(os5));

    rr_select_mux #(.WIDTH(32), .N(3)) dut3 (
        .clk(clk), .reset(reset), .mode(mode3), .sel(sel3),
        .in_valid(valid3), .in_ready(ready3), .in_data(data3),
`ifdef RR_MUX_LOCK_EN
        .in_lock(lock3),
`endif
        .out_valid(ov3), .out_ready(or3), .out_data(od3), .out_src(os3));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the N=8 instance: pending beat, rr pointer and lock, from the behavioural rules.
    logic        m_valid;
    logic [31:0] m_data;
    int          m_src, m_ptr, m_lock_ch, mg;
    bit          m_lock;

    function automatic int m_grant(logic md, logic [2:0] s, logic [7:0] v, int p, bit lk, int lch);
        int c;
        if (!md) return v[s] ? int'(s) : -1;
        for (int off = 0; off < 8; off++) begin
            c = (p + off) % 8;
            if (v[c] && (!lk || c == lch)) return c;
        end
        return -1;
    endfunction

    always_comb mg = m_grant(mode8, sel8, valid8, m_ptr, m_lock, m_lock_ch);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_src     <= 0;
            m_ptr     <= 0;
            m_lock    <= 1'b0;
            m_lock_ch <= 0;
        end else begin
`ifdef RR_MUX_LOCK_EN
            if (!mode8) m_lock <= 1'b0;
            else if ((!m_valid || or8) && mg >= 0) begin
                m_lock    <= lock8[mg];
                m_lock_ch <= mg;
            end
`endif
            if (!m_valid || or8) begin
                m_valid <= (mg >= 0);
                if (mg >= 0) begin
                    m_data <= data8[mg];
                    m_src  <= mg;
                    if (mode8) m_ptr <= (mg + 1) % 8;
                end
            end
        end
    end

    function automatic logic [7:0] m_ready();
        if (reset || (m_valid && !or8) || mg < 0) return 8'h00;
        return 8'(1) << mg;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model out_valid", 32'(ov8), 32'(m_valid));
            chk("model in_ready", 32'(ready8), 32'(m_ready()));
            if (m_valid || reset) begin
                chk("model out_data", od8, m_data);
                chk("model out_src", 32'(os8), 32'(m_src));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    int exp_rr [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};

    initial begin
        for (int i = 0; i < 8; i++) data8[i] = 32'h1000_0000 + 32'(i);
        for (int i = 0; i < 5; i++) data5[i] = 32'h5000_0000 + 32'(i);
        for (int i = 0; i < 3; i++) data3[i] = 32'h3000_0000 + 32'(i);
        #1 reset = 1'b1;
        #1 cmp_en = 1'b1;
        valid8 = 8'hFF;
        valid5 = 5'h1F;
        look();
        chk("reset ov8", 32'(ov8), 32'd0);
        chk("reset od8", od8, 32'd0);
        chk("reset ready8", 32'(ready8), 32'd0);
        chk("reset ready5", 32'(ready5), 32'd0);
        chk("reset os5", 32'(os5), 32'd0);
        tick(); reset = 1'b0; valid8 = '0; valid5 = '0;

        // N=5 round robin from ptr=2 with channels 1 and 4 valid
        valid5 = 5'b00010;
        look(); chk("n5 setup ready", 32'(ready5), 32'h02);
        tick(); valid5 = 5'b10010;
        look(); chk("n5 setup src", 32'(os5), 32'd1);
        chk("n5 ready ptr2", 32'(ready5), 32'h10);
        tick();
        look(); chk("n5 src 4", 32'(os5), 32'd4);
        chk("n5 ready wrap", 32'(ready5), 32'h02);
        tick();
        look(); chk("n5 src 1", 32'(os5), 32'd1);
        chk("n5 data 1", od5, 32'h5000_0001);
        tick(); valid5 = '0;
        look(); chk("n5 src 4 again", 32'(os5), 32'd4);
        tick();
        look(); chk("n5 drain", 32'(ov5), 32'd0);

        // N=3 explicit with out-of-range select
        valid3 = 3'b111;
        look(); chk("n3 sel0 ready", 32'(ready3), 32'h1);
        tick(); sel3 = 2'd3;
        look(); chk("n3 beat valid", 32'(ov3), 32'd1);
        chk("n3 sel3 ready", 32'(ready3), 32'h0);
        tick();
        look(); chk("n3 sel3 drops valid", 32'(ov3), 32'd0);
        tick(); valid3 = '0;

        // N=8 explicit select
        sel8 = 3'd5; valid8 = 8'h20; data8[5] = 32'hDEAD_BEEF;
        look(); chk("explicit ready", 32'(ready8), 32'h20);
        tick(); valid8 = '0;
        look(); chk("explicit ov", 32'(ov8), 32'd1);
        chk("explicit data", od8, 32'hDEAD_BEEF);
        chk("explicit src", 32'(os8), 32'd5);
        tick(); mode8 = 1'b1; valid8 = 8'hFF;

        // N=8 round robin, all channels valid
        for (int i = 0; i < 10; i++) begin
            tick();
            look(); chk("rr sequence", 32'(os8), 32'(exp_rr[i]));
        end

        // Backpressure holds the beat
        tick(); or8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            look();
            chk("stall src", 32'(os8), 32'd2);
            chk("stall data", od8, 32'h1000_0002);
            chk("stall ready", 32'(ready8), 32'h0);
            tick();
        end
        or8 = 1'b1;
        look(); chk("release ready", 32'(ready8), 32'h08);
        tick();
        look(); chk("release src", 32'(os8), 32'd3);

        // Reset mid-stream
        tick(); reset = 1'b1;
        look(); chk("midreset ov", 32'(ov8), 32'd0);
        chk("midreset src", 32'(os8), 32'd0);
        chk("midreset ready", 32'(ready8), 32'd0);
        tick(); reset = 1'b0;
        look(); chk("post reset ready", 32'(ready8), 32'h01);
        tick();
        look(); chk("post reset src", 32'(os8), 32'd0);
        chk("post reset data", od8, 32'h1000_0000);

`ifdef RR_MUX_LOCK_EN
        tick(); valid8 = 8'h04; lock8 = 8'h04;
        tick(); valid8 = 8'h07;
        look(); chk("lock beat 1", 32'(os8), 32'd2);
        tick(); lock8 = 8'h00;
        look(); chk("lock beat 2", 32'(os8), 32'd2);
        tick();
        look(); chk("lock beat 3", 32'(os8), 32'd2);
        tick();
        look(); chk("unlock next", 32'(os8), 32'd0);
        tick(); valid8 = 8'h04; lock8 = 8'h04;
        tick(); valid8 = 8'h03;
        look(); chk("lock hold src", 32'(os8), 32'd2);
        tick();
        look(); chk("lock stall ov", 32'(ov8), 32'd0);
        chk("lock stall ready", 32'(ready8), 32'h0);
        tick(); valid8 = 8'h07; lock8 = 8'h00;
        look(); chk("lock return ready", 32'(ready8), 32'h04);
        tick();
        look(); chk("lock return src", 32'(os8), 32'd2);
`endif

        tick(); valid8 = '0;
        tick();
        tick();
        look();
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
